uart_tx_sched: RTL and testbench



---
 rtl/uart_tx_sched.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Packet scheduler sharing one UART TX serializer between two byte-stream requesters:
// round-robin grant, COM1/COM2 header capture, safe port switch and stall timeout.
module uart_tx_sched #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic       uart_clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       tx_last,
    input  logic       tx_ready,
    input  logic       tx_busy,
    output logic       com_sel,
    output logic [1:0] grant,
    output logic       cmd_pulse,
    output logic       abort_pulse
);
    localparam int unsigned DW = 8;
    localparam int unsigned TW = 16;
    localparam int unsigned HN = 4;

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_SWITCH, S_REPLAY, S_STREAM} state_t;

    state_t          r_state, w_nxt_state;
    logic [1:0]      r_grant, w_nxt_grant;
    logic            r_last_owner, w_nxt_last_owner;
    logic            r_com_sel, w_nxt_com_sel;
    logic            r_new_sel, w_nxt_new_sel;
    logic            r_last_seen, w_nxt_last_seen;
    logic [1:0]      r_idx, w_nxt_idx;
    logic [2:0]      r_cnt, w_nxt_cnt;
    logic [1:0]      r_rptr, w_nxt_rptr;
    logic [TW-1:0]   r_to_cnt, w_nxt_to_cnt;
    logic            r_cmd_pulse, w_nxt_cmd_pulse;
    logic            r_abort_pulse, w_nxt_abort_pulse;
    logic [DW-1:0]   r_hbuf [HN];

    logic            w_hbuf_we;
    logic            w_ready;
    logic            w_gv;
    logic [DW-1:0]   w_gdata;
    logic            w_glast;
    logic            w_match;
    logic            w_timeout;
    logic            w_rlast;

    // Signals of whichever requester currently owns the line
    assign w_gv      = r_grant[1] ? req1_valid : req0_valid;
    assign w_gdata   = r_grant[1] ? req1_data  : req0_data;
    assign w_glast   = r_grant[1] ? req1_last  : req0_last;
    assign w_timeout = (r_to_cnt == TW'(TIMEOUT - 1));
    assign w_rlast   = (3'(r_rptr) == (r_cnt - 3'd1));

    always_comb begin
        w_match = 1'b0;
        case (r_idx)
            2'd0:    w_match = (w_gdata == 8'h43);
            2'd1:    w_match = (w_gdata == 8'h4F);
            2'd2:    w_match = (w_gdata == 8'h4D);
            default: w_match = (w_gdata == 8'h31) || (w_gdata == 8'h32);
        endcase
    end

    always_comb begin
        w_nxt_state       = r_state;
        w_nxt_grant       = r_grant;
        w_nxt_last_owner  = r_last_owner;
        w_nxt_com_sel     = r_com_sel;
        w_nxt_new_sel     = r_new_sel;
        w_nxt_last_seen   = r_last_seen;
        w_nxt_idx         = r_idx;
        w_nxt_cnt         = r_cnt;
        w_nxt_rptr        = r_rptr;
        w_nxt_to_cnt      = '0;
        w_nxt_cmd_pulse   = 1'b0;
        w_nxt_abort_pulse = 1'b0;
        w_hbuf_we         = 1'b0;
        w_ready           = 1'b0;
        tx_valid          = 1'b0;
        tx_data           = '0;
        tx_last           = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_nxt_idx       = '0;
                w_nxt_rptr      = '0;
                w_nxt_last_seen = 1'b0;
                if (req0_valid && (!req1_valid || r_last_owner)) begin
                    w_nxt_grant      = 2'b01;
                    w_nxt_last_owner = 1'b0;
                    w_nxt_state      = S_HDR;
                end else if (req1_valid) begin
                    w_nxt_grant      = 2'b10;
                    w_nxt_last_owner = 1'b1;
                    w_nxt_state      = S_HDR;
                end
            end
            S_HDR: begin
                w_ready = 1'b1;
                if (w_gv) begin
                    w_hbuf_we = 1'b1;
                    if (!w_match) begin
                        w_nxt_cnt       = 3'(r_idx) + 3'd1;
                        w_nxt_last_seen = w_glast;
                        w_nxt_state     = S_REPLAY;
                    end else if (r_idx == 2'd3) begin
                        // '1' (0x31) selects COM1 and '2' (0x32) COM2, so bit 1 carries the port
                        w_nxt_new_sel   = w_gdata[1];
                        w_nxt_last_seen = w_glast;
                        w_nxt_state     = S_SWITCH;
                    end else if (w_glast) begin
                        w_nxt_cnt       = 3'(r_idx) + 3'd1;
                        w_nxt_last_seen = 1'b1;
                        w_nxt_state     = S_REPLAY;
                    end else begin
                        w_nxt_idx = r_idx + 2'd1;
                    end
                end else if (w_timeout) begin
                    w_nxt_abort_pulse = 1'b1;
                    w_nxt_grant       = 2'b00;
                    if (r_idx != 2'd0) begin
                        w_nxt_cnt       = 3'(r_idx);
                        w_nxt_last_seen = 1'b1;
                        w_nxt_state     = S_REPLAY;
                    end else begin
                        w_nxt_state = S_IDLE;
                    end
                end else begin
                    w_nxt_to_cnt = r_to_cnt + TW'(1);
                end
            end
            S_SWITCH: begin
                // Hold the port until the serializer has finished its current frame
                if (!tx_busy) begin
                    w_nxt_com_sel   = r_new_sel;
                    w_nxt_cmd_pulse = 1'b1;
                    if (r_last_seen) begin
                        w_nxt_grant = 2'b00;
                        w_nxt_state = S_IDLE;
                    end else begin
                        w_nxt_state = S_STREAM;
                    end
                end
            end
            S_REPLAY: begin
                tx_valid = 1'b1;
                tx_data  = r_hbuf[r_rptr];
                tx_last  = r_last_seen && w_rlast;
                if (tx_ready) begin
                    if (w_rlast) begin
                        if (r_last_seen) begin
                            w_nxt_grant = 2'b00;
                            w_nxt_state = S_IDLE;
                        end else begin
                            w_nxt_state = S_STREAM;
                        end
                    end else begin
                        w_nxt_rptr = r_rptr + 2'd1;
                    end
                end
            end
            S_STREAM: begin
                tx_valid = w_gv;
                tx_data  = w_gdata;
                tx_last  = w_glast;
                w_ready  = tx_ready;
                if (w_gv) begin
                    if (tx_ready && w_glast) begin
                        w_nxt_grant = 2'b00;
                        w_nxt_state = S_IDLE;
                    end
                end else if (w_timeout) begin
                    w_nxt_abort_pulse = 1'b1;
                    w_nxt_grant       = 2'b00;
                    w_nxt_state       = S_IDLE;
                end else begin
                    w_nxt_to_cnt = r_to_cnt + TW'(1);
                end
            end
            default: begin
                w_nxt_grant = 2'b00;
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_grant       <= 2'b00;
            r_last_owner  <= 1'b1;
            r_com_sel     <= 1'b0;
            r_new_sel     <= 1'b0;
            r_last_seen   <= 1'b0;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_rptr        <= '0;
            r_to_cnt      <= '0;
            r_cmd_pulse   <= 1'b0;
            r_abort_pulse <= 1'b0;
            for (int i = 0; i < int'(HN); i++) r_hbuf[i] <= '0;
        end else begin
            r_state       <= w_nxt_state;
            r_grant       <= w_nxt_grant;
            r_last_owner  <= w_nxt_last_owner;
            r_com_sel     <= w_nxt_com_sel;
            r_new_sel     <= w_nxt_new_sel;
            r_last_seen   <= w_nxt_last_seen;
            r_idx         <= w_nxt_idx;
            r_cnt         <= w_nxt_cnt;
            r_rptr        <= w_nxt_rptr;
            r_to_cnt      <= w_nxt_to_cnt;
            r_cmd_pulse   <= w_nxt_cmd_pulse;
            r_abort_pulse <= w_nxt_abort_pulse;
            if (w_hbuf_we) r_hbuf[r_idx] <= w_gdata;
        end
    end

    assign req0_ready  = w_ready & r_grant[0];
    assign req1_ready  = w_ready & r_grant[1];
    assign com_sel     = r_com_sel;
    assign grant       = r_grant;
    assign cmd_pulse   = r_cmd_pulse;
    assign abort_pulse = r_abort_pulse;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: expected tx bytes queued at stimulus time,
// popped on every tx handshake; grant order, pulses and com_sel checked per scenario.
module tb_uart_tx_sched;
    localparam int unsigned TO = 20;

    logic       uart_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req0_last = 1'b0, req0_ready;
    logic [7:0] req0_data = 8'h00;
    logic       req1_valid = 1'b0, req1_last = 1'b0, req1_ready;
    logic [7:0] req1_data = 8'h00;
    logic       tx_valid, tx_last;
    logic [7:0] tx_data;
    logic       tx_ready = 1'b1, tx_busy = 1'b0;
    logic       com_sel, cmd_pulse, abort_pulse;
    logic [1:0] grant;

    uart_tx_sched #(.TIMEOUT(TO)) dut (
        .uart_clk(uart_clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
        .tx_busy(tx_busy), .com_sel(com_sel), .grant(grant),
        .cmd_pulse(cmd_pulse), .abort_pulse(abort_pulse)
    );

    always #5 uart_clk = ~uart_clk;

    int         n_checks = 0, n_fail = 0;
    int         cyc = 0, cmd_cyc = -1, busy_fall = 0;
    int         n_cmd = 0, n_abort = 0, cmd0 = 0, abort0 = 0;
    bit         rand_ready = 1'b0;
    logic [8:0] sb_q[$];
    logic [1:0] g_log[$];
    logic [1:0] g_prev = 2'b00;
    logic [8:0] sb_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge uart_clk) cyc <= cyc + 1;

    always @(posedge uart_clk) begin
        #1;
        tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: scoreboard pops, pulse counters, grant-change log
    always @(negedge uart_clk) begin
        if (rst_n) begin
            if (tx_valid && tx_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_nonempty", 32'(sb_q.size()), 32'd1);
                end else begin
                    sb_exp = sb_q.pop_front();
                    check("tx_byte", 32'({tx_last, tx_data}), 32'(sb_exp));
                end
            end
            if (cmd_pulse) begin
                n_cmd++;
                cmd_cyc = cyc;
            end
            if (abort_pulse) n_abort++;
            if (grant != g_prev && grant != 2'b00) g_log.push_back(g_prev == 2'b00 ? grant : 2'b11);
        end
        g_prev = grant;
    end

    task automatic drive(input int r, input logic v, input logic [7:0] d, input logic l);
        if (r == 0) begin
            req0_valid = v; req0_data = d; req0_last = l;
        end else begin
            req1_valid = v; req1_data = d; req1_last = l;
        end
    endtask

    task automatic send(input int r, input logic [63:0] b, input int n, input bit lst);
        for (int i = 0; i < n; i++) begin
            int  t;
            logic acc;
            t   = 0;
            acc = 1'b0;
            drive(r, 1'b1, b[8*i +: 8], lst && (i == n - 1));
            do begin
                @(negedge uart_clk);
                acc = (r == 0) ? req0_ready : req1_ready;
                t++;
            end while (!acc && t < 200);
            check("req_ready_wait", 32'(acc), 32'd1);
            @(posedge uart_clk);
            #1;
        end
        drive(r, 1'b0, 8'h00, 1'b0);
    endtask

    // Reference model: a complete COM1/COM2 header is consumed, everything else forwarded
    task automatic expect_pkt(input logic [63:0] b, input int n, input bit lst);
        int first;
        first = 0;
        if (n >= 4 && b[7:0] == 8'h43 && b[15:8] == 8'h4F && b[23:16] == 8'h4D &&
            (b[31:24] == 8'h31 || b[31:24] == 8'h32)) first = 4;
        for (int i = first; i < n; i++) sb_q.push_back({lst && (i == n - 1), b[8*i +: 8]});
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 500) begin
            @(negedge uart_clk);
            t++;
        end
        check(tag, 32'(sb_q.size()), 32'd0);
        repeat (4) @(posedge uart_clk);
        #1;
    endtask

    task automatic check_grants(input string tag, input logic [7:0] exp, input int n);
        check(tag, 32'(g_log.size()), 32'(n));
        for (int i = 0; i < n && i < g_log.size(); i++) check(tag, 32'(g_log[i]), 32'(exp[2*i +: 2]));
    endtask

    task automatic start_scn();
        g_log.delete();
        cmd0   = n_cmd;
        abort0 = n_abort;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge uart_clk);
        @(negedge uart_clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_com_sel", 32'(com_sel), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        check("rst_pulses", 32'({cmd_pulse, abort_pulse}), 32'd0);
        @(posedge uart_clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge uart_clk);
        #1;

        // Both requesters contending: strict alternation starting with req0
        start_scn();
        rand_ready = 1'b1;
        expect_pkt(64'h1211, 2, 1'b1);
        expect_pkt(64'h2221, 2, 1'b1);
        expect_pkt(64'h1413, 2, 1'b1);
        expect_pkt(64'h2423, 2, 1'b1);
        fork
            begin send(0, 64'h1211, 2, 1'b1); send(0, 64'h1413, 2, 1'b1); end
            begin send(1, 64'h2221, 2, 1'b1); send(1, 64'h2423, 2, 1'b1); end
        join
        drain("rr_drain");
        rand_ready = 1'b0;
        check_grants("rr_grants", 8'b10_01_10_01, 4);

        // Plain packet: first byte replayed, rest streamed
        start_scn();
        expect_pkt(64'h4241, 2, 1'b1);
        send(0, 64'h4241, 2, 1'b1);
        drain("plain_drain");
        check_grants("plain_grant", 8'b01, 1);
        check("plain_com_sel", 32'(com_sel), 32'd0);
        check("plain_cmd", 32'(n_cmd - cmd0), 32'd0);
        check("plain_grant_idle", 32'(grant), 32'd0);

        // COM2 header held in SWITCH while the serializer is busy
        start_scn();
        tx_busy = 1'b1;
        expect_pkt(64'h55_32_4D_4F_43, 5, 1'b1);
        fork
            send(1, 64'h55_32_4D_4F_43, 5, 1'b1);
            begin
                repeat (10) @(posedge uart_clk);
                #1;
                tx_busy   = 1'b0;
                busy_fall = cyc;
            end
        join
        drain("com2_drain");
        check("com2_com_sel", 32'(com_sel), 32'd1);
        check("com2_cmd_cnt", 32'(n_cmd - cmd0), 32'd1);
        check("com2_cmd_cyc", 32'(cmd_cyc), 32'(busy_fall + 1));

        // Header broken at the third byte: all three forwarded, port untouched
        start_scn();
        rand_ready = 1'b1;
        expect_pkt(64'h58_4F_43, 3, 1'b1);
        send(0, 64'h58_4F_43, 3, 1'b1);
        drain("part_drain");
        rand_ready = 1'b0;
        check("part_com_sel", 32'(com_sel), 32'd1);
        check("part_cmd", 32'(n_cmd - cmd0), 32'd0);

        // Stall after one header byte: abort, replay with last, then waiting req1 served
        start_scn();
        sb_q.push_back({1'b1, 8'h43});
        expect_pkt(64'h6261, 2, 1'b1);
        fork
            send(0, 64'h43, 1, 1'b0);
            begin
                repeat (3) @(posedge uart_clk);
                #1;
                send(1, 64'h6261, 2, 1'b1);
            end
        join
        drain("to_drain");
        check("to_abort", 32'(n_abort - abort0), 32'd1);
        check_grants("to_grants", 8'b10_01, 2);
        check("to_cmd", 32'(n_cmd - cmd0), 32'd0);

        // COM1-only packet: port switched back, nothing transmitted
        start_scn();
        send(1, 64'h31_4D_4F_43, 4, 1'b1);
        drain("com1_drain");
        check("com1_com_sel", 32'(com_sel), 32'd0);
        check("com1_cmd", 32'(n_cmd - cmd0), 32'd1);
        check("com1_abort", 32'(n_abort - abort0), 32'd0);
        check("com1_grant_idle", 32'(grant), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
